// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the fetch-side branch predictor: 2-bit counter
// encodings, reset/allocation counter values and the sequential PC increment.
package branch_predictor_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    localparam ctr_e        CTR_RESET = WNT;
    localparam ctr_e        CTR_ALLOC = WT;
    localparam logic [31:0] PC_INC    = 32'd4;

    function automatic logic ctr_predicts_taken(input ctr_e c);
        return (c == WT) || (c == ST);
    endfunction

endpackage

// File: rtl/branch_sat_ctr.sv
// Two-bit saturating counter step: increments on taken, decrements on
// not-taken, holding at ST and SNT respectively.
module branch_sat_ctr
    import branch_predictor_pkg::*;
(
    input  ctr_e ctr_in,
    input  logic taken,
    output ctr_e ctr_out
);

    always_comb begin
        ctr_out = ctr_in;
        if (taken) begin
            if (ctr_in != ST) begin
                ctr_out = ctr_e'(ctr_in + 2'd1);
            end
        end else begin
            if (ctr_in != SNT) begin
                ctr_out = ctr_e'(ctr_in - 2'd1);
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB + 2-bit counter predictor with EX-stage mispredict/redirect.
// Optional performance counters are enabled by defining BRANCH_PRED_STATS_EN.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int IDX_W = 4,
    parameter int TAG_W = 26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] fetch_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_pred_taken,
    input  logic [31:0] upd_pred_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc
`ifdef BRANCH_PRED_STATS_EN
    ,
    output logic [31:0] stat_lookups,
    output logic [31:0] stat_updates,
    output logic [31:0] stat_mispredicts
`endif
);

    localparam int ENTRIES = 1 << IDX_W;

    logic              valid_q  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [31:0]       target_q [ENTRIES];
    ctr_e              ctr_q    [ENTRIES];

    // Lookup reads only registered state, so a same-cycle update is not visible.
    logic [IDX_W-1:0] fetch_idx;
    logic [TAG_W-1:0] fetch_tag;
    logic             fetch_hit;

    assign fetch_idx   = fetch_pc[IDX_W+1:2];
    assign fetch_tag   = fetch_pc[31:IDX_W+2];
    assign fetch_hit   = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
    assign pred_taken  = !rst && fetch_hit && ctr_predicts_taken(ctr_q[fetch_idx]);
    assign pred_target = pred_taken ? target_q[fetch_idx] : fetch_pc + PC_INC;

    // upd_valid has no ready: EX presents one resolved transfer per cycle and
    // it is always consumed (trained and checked) in that same cycle.
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;
    ctr_e             ctr_next;

    assign upd_idx = upd_pc[IDX_W+1:2];
    assign upd_tag = upd_pc[31:IDX_W+2];
    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    branch_sat_ctr u_sat_ctr (
        .ctr_in  (ctr_q[upd_idx]),
        .taken   (upd_taken),
        .ctr_out (ctr_next)
    );

    assign mispredict  = !rst && upd_valid &&
                         ((upd_taken != upd_pred_taken) ||
                          (upd_taken && (upd_target != upd_pred_target)));
    assign redirect_pc = mispredict ? (upd_taken ? upd_target : upd_pc + PC_INC) : 32'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= 32'd0;
                ctr_q[i]    <= CTR_RESET;
            end
        end else if (upd_valid) begin
            if (upd_hit) begin
                ctr_q[upd_idx] <= ctr_next;
                if (upd_taken) begin
                    target_q[upd_idx] <= upd_target;
                end
            end else if (upd_taken) begin
                // Taken miss allocates (or evicts an alias); not-taken misses are dropped.
                valid_q[upd_idx]  <= 1'b1;
                tag_q[upd_idx]    <= upd_tag;
                target_q[upd_idx] <= upd_target;
                ctr_q[upd_idx]    <= CTR_ALLOC;
            end
        end
    end

`ifdef BRANCH_PRED_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_lookups     <= 32'd0;
            stat_updates     <= 32'd0;
            stat_mispredicts <= 32'd0;
        end else begin
            if (pred_taken) begin
                stat_lookups <= stat_lookups + 32'd1;
            end
            if (upd_valid) begin
                stat_updates <= stat_updates + 32'd1;
            end
            if (mispredict) begin
                stat_mispredicts <= stat_mispredicts + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed scoreboard bench for branch_predictor: the driver pushes the expected
// {pred_taken, pred_target, mispredict, redirect_pc} per cycle, the monitor checks it.
module tb_branch_predictor;

    localparam int W = 66;
    localparam logic [31:0] A     = 32'h0040_0010;
    localparam logic [31:0] B     = 32'h0040_1010;
    localparam logic [31:0] C     = 32'h0000_0020;
    localparam logic [31:0] T40   = 32'h0040_0040;
    localparam logic [31:0] T80   = 32'h0040_0080;
    localparam logic [31:0] T2000 = 32'h0040_2000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] fetch_pc = 32'd0;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = 32'd0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = 32'd0;
    logic        upd_pred_taken = 1'b0;
    logic [31:0] upd_pred_target = 32'd0;
    logic        mispredict;
    logic [31:0] redirect_pc;
`ifdef BRANCH_PRED_STATS_EN
    logic [31:0] stat_lookups;
    logic [31:0] stat_updates;
    logic [31:0] stat_mispredicts;
`endif

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    logic         sample_en = 1'b0;
    int           check_cnt = 0;
    int           pass_cnt  = 0;

    branch_predictor dut (
        .clk             (clk),
        .rst             (rst),
        .fetch_pc        (fetch_pc),
        .pred_taken      (pred_taken),
        .pred_target     (pred_target),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_taken       (upd_taken),
        .upd_target      (upd_target),
        .upd_pred_taken  (upd_pred_taken),
        .upd_pred_target (upd_pred_target),
        .mispredict      (mispredict),
        .redirect_pc     (redirect_pc)
`ifdef BRANCH_PRED_STATS_EN
        ,
        .stat_lookups     (stat_lookups),
        .stat_updates     (stat_updates),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic check32(input string nm, input string fld,
                           input logic [31:0] got, input logic [31:0] want);
        check_cnt++;
        if (got === want) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s.%s got 0x%08h expected 0x%08h", nm, fld, got, want);
        end
    endtask

    // Monitor: pops one expected record per sampled cycle, mid-cycle on negedge.
    always @(negedge clk) begin
        logic [W-1:0] exp_v;
        string        nm;
        if (sample_en) begin
            if (exp_q.size() == 0) begin
                check_cnt++;
                $display("FAIL scoreboard_underflow got 0 entries expected 1");
            end else begin
                exp_v = exp_q.pop_front();
                nm    = name_q.pop_front();
                check32(nm, "pred_taken",  {31'd0, pred_taken}, {31'd0, exp_v[65]});
                check32(nm, "pred_target", pred_target, exp_v[64:33]);
                check32(nm, "mispredict",  {31'd0, mispredict}, {31'd0, exp_v[32]});
                check32(nm, "redirect_pc", redirect_pc, exp_v[31:0]);
            end
        end
    end

    // Driver: called at posedge+1, holds inputs for one cycle.
    task automatic step(input logic [31:0] fpc, input logic uv, input logic [31:0] upc,
                        input logic ut, input logic [31:0] utgt,
                        input logic upt, input logic [31:0] uptgt,
                        input logic ept, input logic [31:0] eptgt,
                        input logic emp, input logic [31:0] erpc, input string nm);
        fetch_pc        = fpc;
        upd_valid       = uv;
        upd_pc          = upc;
        upd_taken       = ut;
        upd_target      = utgt;
        upd_pred_taken  = upt;
        upd_pred_target = uptgt;
        exp_q.push_back({ept, eptgt, emp, erpc});
        name_q.push_back(nm);
        sample_en = 1'b1;
        @(posedge clk);
        #1;
        sample_en = 1'b0;
    endtask

    task automatic look(input logic [31:0] fpc, input logic ept,
                        input logic [31:0] eptgt, input string nm);
        step(fpc, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, ept, eptgt, 1'b0, 32'd0, nm);
    endtask

`ifdef BRANCH_PRED_STATS_EN
    task automatic check_stats(input logic [31:0] l, input logic [31:0] u,
                               input logic [31:0] m, input string nm);
        check32(nm, "stat_lookups",     stat_lookups,     l);
        check32(nm, "stat_updates",     stat_updates,     u);
        check32(nm, "stat_mispredicts", stat_mispredicts, m);
    endtask
`endif

    initial begin
        @(posedge clk);
        #1;
        // Reset holds outputs quiet and ignores a would-be mispredicting update.
        rst = 1'b1;
        step(A, 1, A, 1, T40, 0, A + 32'd4, 0, A + 32'd4, 0, 32'd0, "rst_hold");
        rst = 1'b0;
        look(A, 0, A + 32'd4, "reset_miss");

        // Allocation on a taken miss, then a hit.
        step(A, 1, A, 1, T40, 0, A + 32'd4, 0, A + 32'd4, 1, T40, "train_mispredict");
        look(A, 1, T40, "train_hit");

        // Counter walks down: 10 -> 01 -> 00; same-cycle lookup sees the old entry.
        step(A, 1, A, 0, T40, 1, T40, 1, T40, 1, A + 32'd4, "nt_of_pred_taken");
        step(A, 1, A, 0, T40, 0, A + 32'd4, 0, A + 32'd4, 0, 32'd0, "nt_again");
        look(A, 0, A + 32'd4, "ctr_snt");

        // Four taken: 00 -> 01 -> 10 -> 11 -> 11, then one not-taken: 11 -> 10.
        step(A, 1, A, 1, T40, 1, T40, 0, A + 32'd4, 0, 32'd0, "sat_t1");
        step(A, 1, A, 1, T40, 1, T40, 0, A + 32'd4, 0, 32'd0, "sat_t2");
        step(A, 1, A, 1, T40, 1, T40, 1, T40, 0, 32'd0, "sat_t3");
        step(A, 1, A, 1, T40, 1, T40, 1, T40, 0, 32'd0, "sat_t4");
        step(A, 1, A, 0, T40, 1, T40, 1, T40, 1, A + 32'd4, "sat_nt");
        look(A, 1, T40, "sat_still_taken");

        // Right direction, wrong target.
        step(A, 1, A, 1, T80, 1, T40, 1, T40, 1, T80, "target_mismatch");
        look(A, 1, T80, "target_retrained");

        // Aliasing entry at the same index with a different tag.
        look(B, 0, B + 32'd4, "alias_miss");
        step(B, 1, B, 1, T2000, 0, B + 32'd4, 0, B + 32'd4, 1, T2000, "alias_replace");
        look(B, 1, T2000, "alias_hit");
        look(A, 0, A + 32'd4, "alias_evicted");
        step(A, 1, A, 0, T40, 0, A + 32'd4, 0, A + 32'd4, 0, 32'd0, "miss_nt_nowrite");
        look(B, 1, T2000, "miss_nt_kept");
        look(32'h0040_1013, 1, T2000, "low_bits_ignored");

        // Sequential PC wrap on a not-taken redirect.
        step(32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0, 32'd0, 1, 32'h10,
             0, 32'd0, 1, 32'd0, "wrap_redirect");

        step(C, 1, C, 1, 32'h100, 0, C + 32'd4, 0, 32'h24, 1, 32'h100, "train_c");
        look(C, 1, 32'h100, "c_hit");

        // Reset mid-operation clears every entry.
        rst = 1'b1;
        step(C, 1, C, 1, 32'h200, 0, 32'd0, 0, 32'h24, 0, 32'd0, "rst_mid");
        rst = 1'b0;
`ifdef BRANCH_PRED_STATS_EN
        check_stats(32'd0, 32'd0, 32'd0, "stats_after_rst");
`endif
        look(B, 0, B + 32'd4, "post_rst_b");
        look(C, 0, 32'h24, "post_rst_c");

        // Replay: three mispredicts, three updates, three taken predictions.
        step(A, 1, A, 1, T40, 0, A + 32'd4, 0, A + 32'd4, 1, T40, "replay_train");
        look(A, 1, T40, "replay_hit");
        step(A, 1, A, 0, T40, 1, T40, 1, T40, 1, A + 32'd4, "replay_nt");
        step(A, 1, A, 1, T80, 1, T40, 0, A + 32'd4, 1, T80, "replay_tgt");
        look(A, 1, T80, "replay_retrained");
`ifdef BRANCH_PRED_STATS_EN
        check_stats(32'd3, 32'd3, 32'd3, "stats_replay");
`endif

        upd_valid = 1'b0;
        @(negedge clk);
        check32("end", "exp_q_left", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
